axil_mem_responder: RTL and testbench
=====================================

AXIL_MEM_RESPONDER -- requirements
Module: axil_mem_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width; only 32 supported.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address bus width.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h80000000, byte address of word 0.
REQ-004 SHALL have parameter DEPTH, default 1024, memory size in 32-bit words.
REQ-005 SHALL have parameter RD_LAT, default 1, cycles from AR handshake to rvalid; range 1..15.
REQ-006 SHALL have ports: clk in 1 clock; rst_n in 1 reset, asynchronous, active-low.
REQ-007 SHALL have ports: araddr in ADDR_WIDTH; arvalid in 1; arready out 1; rdata out 32; rresp out 2; rvalid out 1; rready in 1.
REQ-008 SHALL have ports: awaddr in ADDR_WIDTH; awvalid in 1; awready out 1; wdata in 32; wstrb in 4; wvalid in 1; wready out 1; bresp out 2; bvalid out 1; bready in 1.

Function
REQ-009 SHALL complete a handshake on any channel only in a cycle where valid and ready are both high at the posedge of clk.
REQ-010 SHALL run a read FSM with states R_IDLE -> R_WAIT -> R_RESP -> R_IDLE.
REQ-011 SHALL assert arready only in R_IDLE; AR handshake latches araddr and moves to R_WAIT with latency counter = RD_LAT-1.
REQ-012 SHALL decrement the counter each cycle in R_WAIT; at 0, capture memory word into rdata, enter R_RESP next cycle with rvalid=1; RD_LAT=1 gives rvalid exactly 1 cycle after AR handshake.
REQ-013 SHALL hold rvalid, rdata, rresp stable in R_RESP until rready; on handshake return to R_IDLE with rvalid=0 (no back-to-back: at most one outstanding read).
REQ-014 SHALL run a write FSM with states W_IDLE, W_ADDR (data received, awaiting address), W_DATA (address received, awaiting data), W_RESP.
REQ-015 SHALL assert awready in W_IDLE and W_DATA-pending-address complement (W_IDLE, W_ADDR) and wready in W_IDLE and W_DATA; simultaneous AW and W in W_IDLE go directly to W_RESP.
REQ-016 SHALL perform the memory write in the cycle both address and data are held, byte lanes per wstrb (bit i -> bits 8i+7:8i), then assert bvalid next cycle; hold bvalid/bresp until bready.
REQ-017 SHALL index memory by (addr - BASE_ADDR) >> 2; addr[1:0] ignored.
REQ-018 SHALL respond SLVERR (2'b10) with rdata=0 and no memory write when addr < BASE_ADDR or index >= DEPTH; otherwise OKAY (2'b00).
REQ-019 SHALL keep read and write FSMs independent; same-word read capture and write in same cycle returns old data.
REQ-020 SHALL ignore wstrb=0 writes to memory but still return OKAY.

Reset
REQ-021 SHALL, on rst_n low, asynchronously force FSMs to R_IDLE/W_IDLE, rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0, counters 0; arready/awready/wready=1 combinationally from idle states.
REQ-022 SHALL abort any in-flight transaction on reset with no response issued; memory contents are not reset.

Configuration
REQ-023 SHALL, with AXIL_MEM_RAND_DELAY_EN defined, replace RD_LAT by 1 + lfsr[2:0] (1..8) sampled at each AR handshake, and delay bvalid by the same-formula sample taken at write commit.
REQ-024 SHALL, without AXIL_MEM_RAND_DELAY_EN, use fixed RD_LAT for reads and 1-cycle write response; no LFSR logic present.

Structure
REQ-025 SHALL place resp codes (RESP_OKAY, RESP_SLVERR) and FSM state enums in shared package axil_pkg.
REQ-026 SHALL use one sub-module lfsr16 (16-bit Galois, taps x16+x14+x13+x11+1, reset seed 16'hACE1), instantiated only under AXIL_MEM_RAND_DELAY_EN.

Verification
REQ-027 Write 0xDEADBEEF wstrb=4'hF to 0x80000010, then read 0x80000010 -> bresp=OKAY, rdata=0xDEADBEEF, rvalid 1 cycle after AR handshake (RD_LAT=1).
REQ-028 Write 0x11223344 then 0xAABBCCDD wstrb=4'b0101 same address -> read returns 0x11BB33DD.
REQ-029 Read 0x7FFFFFFC and 0x80001000 (DEPTH=1024) -> rresp=SLVERR, rdata=0; write there -> bresp=SLVERR, memory unchanged.
REQ-030 Hold rready=0 for 5 cycles after rvalid -> rvalid, rdata stable all 5 cycles; arready=0 throughout.
REQ-031 Present wvalid 3 cycles before awvalid -> write FSM in W_ADDR, wready=0 while waiting, single bvalid after AW handshake.
REQ-032 Drop rst_n during R_WAIT and W_RESP -> rvalid=0, bvalid=0 immediately; after release, arready=awready=wready=1 and previously written data still readable.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared response codes and FSM state encodings for the AXI-Lite memory responder.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int LAT_W = 4;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ADDR,
        W_DATA,
        W_RESP
    } wr_state_t;

endpackage

// File: rtl/axil_mem_responder_lfsr16.sv
// 16-bit Galois LFSR (x^16 + x^14 + x^13 + x^11 + 1), free-running, seeded 16'hACE1 on reset.
module lfsr16 (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] o_lfsr
);

    logic [15:0] r_lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    assign o_lfsr = r_lfsr;

endmodule

// File: rtl/axil_mem_responder.sv
// AXI-Lite word memory with independent read/write FSMs and address-range SLVERR.
// Define AXIL_MEM_RAND_DELAY_EN to randomise read latency and write-response delay (1..8 cycles).
//
// state  | meaning
// R_IDLE | arready high, waiting for an AR handshake
// R_WAIT | latency countdown; memory word captured when the counter is 0
// R_RESP | rvalid/rdata/rresp held until rready
// W_IDLE | awready and wready high, nothing received
// W_ADDR | data held, waiting for the address
// W_DATA | address held, waiting for the data
// W_RESP | write committed; bvalid raised (after delay) and held until bready
module axil_mem_responder #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                    DEPTH      = 1024,
    parameter int                    RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [31:0]           rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [31:0]           wdata,
    input  logic [3:0]            wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready
);

    import axil_pkg::*;

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LAT_W-1:0] RD_LAT_M1 = LAT_W'(RD_LAT - 1);

    rd_state_t              r_rstate;
    wr_state_t              r_wstate;
    logic [ADDR_WIDTH-1:0]  r_araddr;
    logic [ADDR_WIDTH-1:0]  r_awaddr;
    logic [LAT_W-1:0]       r_rcnt;
    logic [2:0]             r_bcnt;
    logic [DATA_WIDTH-1:0]  r_rdata;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic [3:0]             r_wstrb;
    logic [1:0]             r_rresp;
    logic [1:0]             r_bresp;
    logic                   r_rvalid;
    logic                   r_bvalid;
    logic [DATA_WIDTH-1:0]  r_mem [DEPTH];

    logic [ADDR_WIDTH-1:0]  w_ar_off;
    logic                   w_ar_err;
    logic [IDX_W-1:0]       w_ar_idx;
    logic [ADDR_WIDTH-1:0]  w_wr_addr;
    logic [ADDR_WIDTH-1:0]  w_wr_off;
    logic                   w_wr_err;
    logic [IDX_W-1:0]       w_wr_idx;
    logic [DATA_WIDTH-1:0]  w_wr_data;
    logic [3:0]             w_wr_strb;
    logic                   w_commit;
    logic [LAT_W-1:0]       w_rd_lat_m1;
    logic [2:0]             w_wr_dly;

`ifdef AXIL_MEM_RAND_DELAY_EN
    logic [15:0] w_lfsr;

    lfsr16 u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .o_lfsr (w_lfsr)
    );

    assign w_rd_lat_m1 = {1'b0, w_lfsr[2:0]};
    assign w_wr_dly    = w_lfsr[2:0];

    logic w_unused_lfsr;
    assign w_unused_lfsr = ^w_lfsr[15:3];
`else
    assign w_rd_lat_m1 = RD_LAT_M1;
    assign w_wr_dly    = 3'd0;
`endif

    // Word index is the byte offset from BASE_ADDR divided by 4; below-base wraps and is flagged.
    assign w_ar_off = r_araddr - BASE_ADDR;
    assign w_ar_err = (r_araddr < BASE_ADDR) || ((w_ar_off >> 2) >= ADDR_WIDTH'(DEPTH));
    assign w_ar_idx = w_ar_off[IDX_W+1:2];

    assign w_wr_addr = (r_wstate == W_DATA) ? r_awaddr : awaddr;
    assign w_wr_data = (r_wstate == W_ADDR) ? r_wdata  : wdata;
    assign w_wr_strb = (r_wstate == W_ADDR) ? r_wstrb  : wstrb;
    assign w_wr_off  = w_wr_addr - BASE_ADDR;
    assign w_wr_err  = (w_wr_addr < BASE_ADDR) || ((w_wr_off >> 2) >= ADDR_WIDTH'(DEPTH));
    assign w_wr_idx  = w_wr_off[IDX_W+1:2];

    logic w_unused_off;
    assign w_unused_off = ^{w_ar_off[1:0], w_wr_off[1:0]};

    always_comb begin
        w_commit = 1'b0;
        case (r_wstate)
            W_IDLE:  w_commit = awvalid && wvalid;
            W_ADDR:  w_commit = awvalid;
            W_DATA:  w_commit = wvalid;
            default: w_commit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_commit && !w_wr_err) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (w_wr_strb[i]) begin
                    r_mem[w_wr_idx][8*i +: 8] <= w_wr_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rstate <= R_IDLE;
            r_araddr <= '0;
            r_rcnt   <= '0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (arvalid) begin
                        r_araddr <= araddr;
                        r_rcnt   <= w_rd_lat_m1;
                        r_rstate <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (r_rcnt == '0) begin
                        r_rdata  <= w_ar_err ? '0 : r_mem[w_ar_idx];
                        r_rresp  <= w_ar_err ? RESP_SLVERR : RESP_OKAY;
                        r_rvalid <= 1'b1;
                        r_rstate <= R_RESP;
                    end else begin
                        r_rcnt <= r_rcnt - 1'b1;
                    end
                end
                R_RESP: begin
                    if (rready) begin
                        r_rvalid <= 1'b0;
                        r_rstate <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wstate <= W_IDLE;
            r_awaddr <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_bcnt   <= '0;
            r_bvalid <= 1'b0;
            r_bresp  <= RESP_OKAY;
        end else if (w_commit) begin
            // A zero delay sample means bvalid in the cycle right after commit.
            r_bresp  <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
            r_bcnt   <= w_wr_dly;
            r_bvalid <= (w_wr_dly == 3'd0);
            r_wstate <= W_RESP;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (awvalid) begin
                        r_awaddr <= awaddr;
                        r_wstate <= W_DATA;
                    end else if (wvalid) begin
                        r_wdata  <= wdata;
                        r_wstrb  <= wstrb;
                        r_wstate <= W_ADDR;
                    end
                end
                W_RESP: begin
                    if (!r_bvalid) begin
                        r_bcnt <= r_bcnt - 1'b1;
                        if (r_bcnt == 3'd1) begin
                            r_bvalid <= 1'b1;
                        end
                    end else if (bready) begin
                        r_bvalid <= 1'b0;
                        r_wstate <= W_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign arready = (r_rstate == R_IDLE);
    assign awready = (r_wstate == W_IDLE) || (r_wstate == W_ADDR);
    assign wready  = (r_wstate == W_IDLE) || (r_wstate == W_DATA);
    assign rvalid  = r_rvalid;
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;
    assign bvalid  = r_bvalid;
    assign bresp   = r_bresp;

endmodule

// File: tb/tb_axil_mem_responder.sv
// Directed bench for axil_mem_responder (default RD_LAT=1 instance plus an RD_LAT=4 instance).
module tb_axil_mem_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
    logic        arvalid = 0, rready = 0, awvalid = 0, wvalid = 0, bready = 0;
    logic [3:0]  wstrb = '0;
    logic        arready, rvalid, awready, wready, bvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp, bresp;

    logic [31:0] l_araddr = '0;
    logic        l_arvalid = 0, l_rready = 0;
    logic        l_arready, l_rvalid, l_awready, l_wready, l_bvalid;
    logic [31:0] l_rdata;
    logic [1:0]  l_rresp, l_bresp;

    int total = 0;
    int bad = 0;

    axil_mem_responder dut (
        .clk(clk), .rst_n(rst_n),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    axil_mem_responder #(.RD_LAT(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .araddr(l_araddr), .arvalid(l_arvalid), .arready(l_arready),
        .rdata(l_rdata), .rresp(l_rresp), .rvalid(l_rvalid), .rready(l_rready),
        .awaddr(32'h0), .awvalid(1'b0), .awready(l_awready),
        .wdata(32'h0), .wstrb(4'h0), .wvalid(1'b0), .wready(l_wready),
        .bresp(l_bresp), .bvalid(l_bvalid), .bready(1'b0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
        int n;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1; wvalid = 1;
        n = 0;
        while (!(awready && wready) && n < 20) begin tick(); n++; end
        tick();
        awvalid = 0; wvalid = 0;
        bready = 1;
        n = 0;
        while (!bvalid && n < 20) begin tick(); n++; end
        if (!bvalid) begin
            total++; bad++;
            $display("FAIL write_timeout addr=%h: no bvalid within 20 cycles", addr);
        end
        resp = bresp;
        tick();
        bready = 0;
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output int lat);
        int n;
        araddr = addr; arvalid = 1;
        n = 0;
        while (!arready && n < 20) begin tick(); n++; end
        tick();
        arvalid = 0;
        lat = 0;
        while (!rvalid && lat < 20) begin tick(); lat++; end
        data = rdata; resp = rresp;
        rready = 1;
        tick();
        rready = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if ({arready, awready, wready} !== 3'b111) begin bad++;
            $display("FAIL reset_ready got=%b want=111", {arready, awready, wready}); end
        total++; if ({rvalid, bvalid} !== 2'b00) begin bad++;
            $display("FAIL reset_valid got=%b want=00", {rvalid, bvalid}); end
        @(negedge clk);
        rst_n = 1;
        tick();
        total++; if (rdata !== 32'h0 || rresp !== 2'b00 || bresp !== 2'b00) begin bad++;
            $display("FAIL reset_regs rdata=%h rresp=%b bresp=%b want 0", rdata, rresp, bresp); end
        total++; if ({arready, awready, wready, rvalid, bvalid} !== 5'b11100) begin bad++;
            $display("FAIL reset_release got=%b want=11100", {arready, awready, wready, rvalid, bvalid}); end
    endtask

    task automatic test_basic();
        logic [1:0] r; logic [31:0] d; int lat;
        do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, r);
        total++; if (r !== 2'b00) begin bad++; $display("FAIL basic_bresp got=%b want=00", r); end
        do_read(32'h8000_0010, d, r, lat);
        total++; if (d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL basic_rdata got=%h want=deadbeef", d); end
        total++; if (r !== 2'b00) begin bad++; $display("FAIL basic_rresp got=%b want=00", r); end
        total++; if (lat != 1) begin bad++; $display("FAIL basic_latency got=%0d want=1", lat); end
        do_read(32'h8000_0013, d, r, lat);
        total++; if (d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL unaligned_rdata got=%h want=deadbeef", d); end
    endtask

    task automatic test_strobe();
        logic [1:0] r; logic [31:0] d; int lat;
        do_write(32'h8000_0020, 32'h1122_3344, 4'hF, r);
        do_write(32'h8000_0020, 32'hAABB_CCDD, 4'b0101, r);
        do_read(32'h8000_0020, d, r, lat);
        total++; if (d !== 32'h11BB_33DD) begin bad++; $display("FAIL strobe_merge got=%h want=11bb33dd", d); end
        do_write(32'h8000_0040, 32'h0102_0304, 4'hF, r);
        do_write(32'h8000_0040, 32'hFFFF_FFFF, 4'h0, r);
        total++; if (r !== 2'b00) begin bad++; $display("FAIL strobe0_bresp got=%b want=00", r); end
        do_read(32'h8000_0040, d, r, lat);
        total++; if (d !== 32'h0102_0304) begin bad++; $display("FAIL strobe0_data got=%h want=01020304", d); end
    endtask

    task automatic test_slverr();
        logic [1:0] r; logic [31:0] d; int lat;
        do_write(32'h8000_0000, 32'hA5A5_0000, 4'hF, r);
        do_write(32'h8000_0FFC, 32'h5A5A_0FFC, 4'hF, r);
        total++; if (r !== 2'b00) begin bad++; $display("FAIL last_word_bresp got=%b want=00", r); end
        do_read(32'h7FFF_FFFC, d, r, lat);
        total++; if (r !== 2'b10 || d !== 32'h0) begin bad++;
            $display("FAIL below_base_read resp=%b data=%h want 10/0", r, d); end
        do_read(32'h8000_1000, d, r, lat);
        total++; if (r !== 2'b10 || d !== 32'h0) begin bad++;
            $display("FAIL above_depth_read resp=%b data=%h want 10/0", r, d); end
        do_write(32'h8000_1000, 32'hFFFF_FFFF, 4'hF, r);
        total++; if (r !== 2'b10) begin bad++; $display("FAIL above_depth_bresp got=%b want=10", r); end
        do_write(32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF, r);
        total++; if (r !== 2'b10) begin bad++; $display("FAIL below_base_bresp got=%b want=10", r); end
        do_read(32'h8000_0000, d, r, lat);
        total++; if (d !== 32'hA5A5_0000) begin bad++; $display("FAIL word0_untouched got=%h want=a5a50000", d); end
        do_read(32'h8000_0FFC, d, r, lat);
        total++; if (d !== 32'h5A5A_0FFC || r !== 2'b00) begin bad++;
            $display("FAIL last_word_untouched got=%h/%b want=5a5a0ffc/00", d, r); end
    endtask

    task automatic test_rready_stall();
        int n;
        araddr = 32'h8000_0010; arvalid = 1;
        tick();
        arvalid = 0;
        n = 0;
        while (!rvalid && n < 20) begin tick(); n++; end
        for (int i = 0; i < 5; i++) begin
            total++; if (rvalid !== 1'b1 || rdata !== 32'hDEAD_BEEF || arready !== 1'b0) begin bad++;
                $display("FAIL stall_cycle%0d rvalid=%b rdata=%h arready=%b want 1/deadbeef/0",
                         i, rvalid, rdata, arready); end
            tick();
        end
        rready = 1;
        tick();
        rready = 0;
        total++; if (rvalid !== 1'b0 || arready !== 1'b1) begin bad++;
            $display("FAIL stall_release rvalid=%b arready=%b want 0/1", rvalid, arready); end
    endtask

    task automatic test_w_before_aw();
        logic [1:0] r; logic [31:0] d; int lat; int pulses;
        wdata = 32'hCAFE_F00D; wstrb = 4'hF; wvalid = 1;
        tick();
        wvalid = 0;
        for (int i = 0; i < 3; i++) begin
            total++; if ({wready, awready, bvalid} !== 3'b010) begin bad++;
                $display("FAIL w_first_wait%0d wready/awready/bvalid=%b want 010", i, {wready, awready, bvalid}); end
            tick();
        end
        awaddr = 32'h8000_0050; awvalid = 1;
        tick();
        awvalid = 0;
        total++; if (bvalid !== 1'b1 || bresp !== 2'b00) begin bad++;
            $display("FAIL w_first_bvalid bvalid=%b bresp=%b want 1/00", bvalid, bresp); end
        tick();
        total++; if (bvalid !== 1'b1) begin bad++; $display("FAIL w_first_bhold got=%b want=1", bvalid); end
        bready = 1;
        tick();
        bready = 0;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            if (bvalid) pulses++;
            tick();
        end
        total++; if (pulses != 0) begin bad++; $display("FAIL w_first_single_b extra=%0d want=0", pulses); end
        do_read(32'h8000_0050, d, r, lat);
        total++; if (d !== 32'hCAFE_F00D) begin bad++; $display("FAIL w_first_data got=%h want=cafef00d", d); end
    endtask

    task automatic test_aw_before_w();
        logic [1:0] r; logic [31:0] d; int lat;
        awaddr = 32'h8000_0060; awvalid = 1;
        tick();
        awvalid = 0;
        total++; if ({awready, wready, bvalid} !== 3'b010) begin bad++;
            $display("FAIL aw_first_wait awready/wready/bvalid=%b want 010", {awready, wready, bvalid}); end
        wdata = 32'h1357_9BDF; wstrb = 4'hF; wvalid = 1;
        tick();
        wvalid = 0;
        total++; if (bvalid !== 1'b1) begin bad++; $display("FAIL aw_first_bvalid got=%b want=1", bvalid); end
        bready = 1;
        tick();
        bready = 0;
        do_read(32'h8000_0060, d, r, lat);
        total++; if (d !== 32'h1357_9BDF) begin bad++; $display("FAIL aw_first_data got=%h want=13579bdf", d); end
    endtask

    task automatic test_same_cycle();
        logic [1:0] r; logic [31:0] d; int lat;
        do_write(32'h8000_0070, 32'h0000_AAAA, 4'hF, r);
        araddr = 32'h8000_0070; arvalid = 1;
        tick();
        arvalid = 0;
        awaddr = 32'h8000_0070; wdata = 32'h5555_BBBB; wstrb = 4'hF;
        awvalid = 1; wvalid = 1;
        tick();
        awvalid = 0; wvalid = 0;
        total++; if (rvalid !== 1'b1 || rdata !== 32'h0000_AAAA) begin bad++;
            $display("FAIL same_cycle_old rvalid=%b rdata=%h want 1/0000aaaa", rvalid, rdata); end
        rready = 1; bready = 1;
        tick();
        rready = 0; bready = 0;
        do_read(32'h8000_0070, d, r, lat);
        total++; if (d !== 32'h5555_BBBB) begin bad++; $display("FAIL same_cycle_new got=%h want=5555bbbb", d); end
    endtask

    task automatic test_latency4();
        int lat;
        l_araddr = 32'h7FFF_FFFC; l_arvalid = 1;
        tick();
        l_arvalid = 0;
        lat = 0;
        while (!l_rvalid && lat < 20) begin tick(); lat++; end
        total++; if (lat != 4) begin bad++; $display("FAIL latency4 got=%0d want=4", lat); end
        total++; if (l_rresp !== 2'b10 || l_rdata !== 32'h0) begin bad++;
            $display("FAIL latency4_resp resp=%b data=%h want 10/0", l_rresp, l_rdata); end
        l_rready = 1;
        tick();
        l_rready = 0;
    endtask

    task automatic test_reset_midflight();
        logic [1:0] r; logic [31:0] d; int lat;
        araddr = 32'h8000_0010; arvalid = 1;
        awaddr = 32'h8000_0080; wdata = 32'h7777_7777; wstrb = 4'hF;
        awvalid = 1; wvalid = 1;
        tick();
        arvalid = 0; awvalid = 0; wvalid = 0;
        total++; if ({arready, rvalid, bvalid} !== 3'b001) begin bad++;
            $display("FAIL pre_reset arready/rvalid/bvalid=%b want 001", {arready, rvalid, bvalid}); end
        rst_n = 0;
        #1;
        total++; if ({rvalid, bvalid} !== 2'b00) begin bad++;
            $display("FAIL async_reset rvalid/bvalid=%b want 00", {rvalid, bvalid}); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        tick();
        total++; if ({arready, awready, wready, rvalid, bvalid} !== 5'b11100) begin bad++;
            $display("FAIL post_reset got=%b want=11100", {arready, awready, wready, rvalid, bvalid}); end
        tick();
        total++; if ({rvalid, bvalid} !== 2'b00) begin bad++;
            $display("FAIL no_stale_resp rvalid/bvalid=%b want 00", {rvalid, bvalid}); end
        do_read(32'h8000_0010, d, r, lat);
        total++; if (d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL mem_retained got=%h want=deadbeef", d); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_strobe();
        test_slverr();
        test_rready_stall();
        test_w_before_aw();
        test_aw_before_w();
        test_same_cycle();
        test_latency4();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
